// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the PSEC5 SPI initiator.
// Optional receive FIFO is enabled with SPI_CTRL_RX_FIFO_EN.
package spi_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int BYTE_W = 8;

  // Register addresses the bench decodes specially.
  localparam logic [ADDR_W-1:0] SPECIAL_ADDR_FIRST = 8'd1;
  localparam logic [ADDR_W-1:0] SPECIAL_ADDR_LAST  = 8'd3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    GAP,
    DONE
  } state_e;

  // True in the states where the peripheral clock runs and pico carries bits.
  function automatic logic is_shifting(state_e s);
    return (s == ADDR) || (s == DATA);
  endfunction

endpackage

// File: rtl/spi_ctrl_if.sv
// Parallel request/response bus between a host and spi_controller.
// rx_ready / rx_overflow exist only when SPI_CTRL_RX_FIFO_EN is defined.
interface spi_ctrl_if
  import spi_ctrl_pkg::*;
#(
  parameter int LEN_W = 6
);

  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  num_bytes;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_ready;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              done;
`ifdef SPI_CTRL_RX_FIFO_EN
  logic              rx_ready;
  logic              rx_overflow;
`endif

  modport master (
    output start, addr, num_bytes, tx_data,
`ifdef SPI_CTRL_RX_FIFO_EN
    output rx_ready,
    input  rx_overflow,
`endif
    input  tx_ready, rx_data, rx_valid, busy, done
  );

  modport slave (
    input  start, addr, num_bytes, tx_data,
`ifdef SPI_CTRL_RX_FIFO_EN
    input  rx_ready,
    output rx_overflow,
`endif
    output tx_ready, rx_data, rx_valid, busy, done
  );

endinterface

// File: rtl/spi_ctrl_rx_fifo.sv
// Small synchronous FIFO buffering received bytes; used only when
// SPI_CTRL_RX_FIFO_EN is defined. A push while full succeeds only with a pop.
module spi_ctrl_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             sclk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; empty gates every read, so its contents never matter after reset.
  always_ff @(posedge sclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_controller.sv
// SPI initiator for the PSEC5 peripheral: address byte, data bytes, then an
// sclk-stop gap. Define SPI_CTRL_RX_FIFO_EN to buffer received bytes in a FIFO.
module spi_controller
  import spi_ctrl_pkg::*;
#(
  parameter int LEN_W      = 6,
  parameter int GAP_CYCLES = 4
`ifdef SPI_CTRL_RX_FIFO_EN
  , parameter int RX_FIFO_DEPTH = 4
`endif
) (
  input  logic       sclk,
  input  logic       rstn,
  spi_ctrl_if.slave  bus,
  output logic       pico,
  input  logic       poci,
  output logic       sclk_en
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  num_q;
  logic [LEN_W-1:0]  byte_cnt;
  logic [2:0]        bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [BYTE_W-1:0] tx_shift;
  logic [BYTE_W-1:0] rx_shift;
  logic [BYTE_W-1:0] rx_byte;
  logic              byte_push;
  logic              accept;
  logic              last_bit;
  logic              last_byte;
  logic              tx_ready_int;

  assign accept    = (state_q == IDLE) && bus.start;
  assign last_bit  = (bit_cnt == 3'd7);
  assign last_byte = (({1'b0, byte_cnt} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, num_q});

  // State register
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = ADDR;
      ADDR: if (last_bit)  state_d = (num_q == '0) ? GAP : DATA;
      DATA: if (last_bit && last_byte) state_d = GAP;
      GAP:  if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; the next byte is requested at the end of the address byte
  // and at the end of every data byte that has a successor.
  always_comb begin
    tx_ready_int = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    pico         = 1'b0;
    case (state_q)
      ADDR: begin
        bus.busy     = 1'b1;
        pico         = tx_shift[BYTE_W-1];
        tx_ready_int = last_bit && (num_q != '0);
      end
      DATA: begin
        bus.busy     = 1'b1;
        pico         = tx_shift[BYTE_W-1];
        tx_ready_int = last_bit && !last_byte;
      end
      GAP:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
    bus.tx_ready = tx_ready_int;
  end

  // Datapath: shifters, counters, and the registered clock gate enable.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sclk_en   <= 1'b0;
      num_q     <= '0;
      byte_cnt  <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      byte_push <= 1'b0;
    end else begin
      sclk_en   <= is_shifting(state_d);
      byte_push <= (state_q == DATA) && last_bit;
      gap_cnt   <= (state_q == GAP) ? gap_cnt + GAP_W'(1) : '0;

      if (accept) begin
        tx_shift <= bus.addr;
        num_q    <= bus.num_bytes;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (is_shifting(state_q)) begin
        bit_cnt  <= bit_cnt + 3'd1;
        tx_shift <= tx_ready_int ? bus.tx_data : {tx_shift[BYTE_W-2:0], 1'b0};
        if ((state_q == DATA) && last_bit) byte_cnt <= byte_cnt + LEN_W'(1);
      end

      // Address-phase poci is ignored; only data bits are captured.
      if (state_q == DATA) rx_shift <= {rx_shift[BYTE_W-2:0], poci};
      if ((state_q == DATA) && last_bit) rx_byte <= {rx_shift[BYTE_W-2:0], poci};
    end
  end

`ifdef SPI_CTRL_RX_FIFO_EN
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_dout;
  logic              rx_ovf_q;

  assign fifo_pop        = bus.rx_valid && bus.rx_ready;
  assign bus.rx_valid    = !fifo_empty;
  assign bus.rx_data     = fifo_empty ? '0 : fifo_dout;
  assign bus.rx_overflow = rx_ovf_q;

  spi_ctrl_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_rx_fifo (
    .sclk  (sclk),
    .rstn  (rstn),
    .push  (byte_push),
    .din   (rx_byte),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky until the next accepted request; a byte dropped on a full FIFO sets it.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn)                                      rx_ovf_q <= 1'b0;
    else if (accept)                                rx_ovf_q <= 1'b0;
    else if (byte_push && fifo_full && !fifo_pop)   rx_ovf_q <= 1'b1;
  end
`else
  assign bus.rx_valid = byte_push;
  assign bus.rx_data  = rx_byte;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: frame timing, pico/poci data, reset abort,
// ignored starts; RX FIFO checks when SPI_CTRL_RX_FIFO_EN is defined.
module tb_spi_controller;
  import spi_ctrl_pkg::*;

  localparam int LEN_W      = 6;
  localparam int GAP_CYCLES = 4;

  logic sclk = 1'b0;
  logic rstn = 1'b0;
  logic poci = 1'b0;
  logic pico;
  logic sclk_en;

  spi_ctrl_if #(.LEN_W(LEN_W)) bus ();

  spi_controller #(
    .LEN_W      (LEN_W),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .sclk    (sclk),
    .rstn    (rstn),
    .bus     (bus),
    .pico    (pico),
    .poci    (poci),
    .sclk_en (sclk_en)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_bytes [8];
  logic [7:0] rx_bytes [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] out_vec();
    return {bus.busy, bus.done, bus.tx_ready, bus.rx_valid, sclk_en, pico, bus.rx_data};
  endfunction

  // One frame; cycle 0 carries start, cycle k is sampled on the negedge after the k-th posedge.
  task automatic run_frame(input logic [7:0] a, input int n, input int spur_a,
                           input int spur_b, input string tag);
    logic [63:0] pico_seq = '0;
    logic [63:0] exp_seq  = '0;
    int en_cnt = 0, en_first = -1, en_last = -1;
    int txr_cnt = 0, txr_first = -1, tx_idx = 0;
    int rxv_cnt = 0, done_cyc = -1, idle_pico = 0, after = 0;
    @(negedge sclk);
    bus.start     = 1'b1;
    bus.addr      = a;
    bus.num_bytes = LEN_W'(n);
    bus.tx_data   = 8'h00;
    poci          = 1'b1;
    for (int k = 1; k <= 200 && done_cyc < 0; k++) begin
      @(negedge sclk);
      if (sclk_en) begin
        en_cnt++;
        if (en_first < 0) en_first = k;
        en_last  = k;
        pico_seq = {pico_seq[62:0], pico};
      end else if (pico) idle_pico++;
      if (bus.tx_ready) begin
        txr_cnt++;
        if (txr_first < 0) txr_first = k;
        if (tx_idx < 8) bus.tx_data = tx_bytes[tx_idx];
        tx_idx++;
      end
`ifndef SPI_CTRL_RX_FIFO_EN
      if (bus.rx_valid) begin
        check({tag, ".rx_cycle"}, 64'(k), 64'(17 + 8 * rxv_cnt));
        if (rxv_cnt < 8) check({tag, ".rx_data"}, 64'(bus.rx_data), 64'(rx_bytes[rxv_cnt]));
        rxv_cnt++;
      end
`endif
      if (k == 1) check({tag, ".busy_c1"}, 64'(bus.busy), 64'd1);
      if (bus.done) begin
        done_cyc = k;
        check({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
      end
      bus.start = (k == spur_a) || (k == spur_b);
      if (k >= 9 && k < 9 + 8 * n) poci = rx_bytes[(k - 9) / 8][7 - ((k - 9) % 8)];
      else                         poci = 1'b1;
    end
    @(posedge sclk);
    #1 bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge sclk);
      if (sclk_en || bus.busy) after++;
    end

    exp_seq = 64'(a);
    for (int i = 0; i < n; i++) exp_seq = (exp_seq << 8) | 64'(tx_bytes[i]);
    check({tag, ".done_cycle"}, 64'(done_cyc), 64'(13 + 8 * n));
    check({tag, ".en_count"},   64'(en_cnt),   64'(8 + 8 * n));
    check({tag, ".en_first"},   64'(en_first), 64'd1);
    check({tag, ".en_last"},    64'(en_last),  64'(8 + 8 * n));
    check({tag, ".pico_bits"},  pico_seq,      exp_seq);
    check({tag, ".pico_idle"},  64'(idle_pico), 64'd0);
    check({tag, ".tx_ready_n"}, 64'(txr_cnt),  64'(n));
    if (n > 0) check({tag, ".tx_ready_c"}, 64'(txr_first), 64'd8);
`ifndef SPI_CTRL_RX_FIFO_EN
    check({tag, ".rx_valid_n"}, 64'(rxv_cnt), 64'(n));
`endif
    check({tag, ".no_refire"}, 64'(after), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.start     = 1'b0;
    bus.addr      = '0;
    bus.num_bytes = '0;
    bus.tx_data   = '0;
`ifdef SPI_CTRL_RX_FIFO_EN
    bus.rx_ready  = 1'b1;
`endif
    repeat (2) @(negedge sclk);
    check("reset.outputs", 64'(out_vec()), 64'd0);
    rstn = 1'b1;
    @(negedge sclk);

    // Single write: pico 0x02 then 0xA5, done at cycle 21.
    tx_bytes[0] = 8'hA5;
    rx_bytes[0] = 8'h5C;
    run_frame(8'h02, 1, -1, -1, "write1");

    // Read burst: three bytes back on poci.
    tx_bytes[0] = 8'h3C; tx_bytes[1] = 8'hC3; tx_bytes[2] = 8'h0F;
    rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h33;
    run_frame(8'h04, 3, -1, -1, "burst3");

    // Zero length: address only, done at cycle 13.
    run_frame(SPECIAL_ADDR_FIRST, 0, -1, -1, "zero");

    // Starts during ADDR (cycle 3) and during DONE (cycle 21) are ignored.
    tx_bytes[0] = 8'h81;
    rx_bytes[0] = 8'h7E;
    run_frame(8'h9E, 1, 3, 21, "spur");

    // Async reset mid-DATA aborts the frame with no done.
    @(negedge sclk);
    bus.start = 1'b1; bus.addr = 8'hF0; bus.num_bytes = LEN_W'(2); bus.tx_data = 8'hFF;
    @(negedge sclk);
    bus.start = 1'b0;
    repeat (11) @(negedge sclk);
    check("abort.in_data", 64'(sclk_en), 64'd1);
    rstn = 1'b0;
    #1 check("abort.outputs", 64'(out_vec()), 64'd0);
    begin
      int seen_done = 0;
      repeat (2) begin
        @(negedge sclk);
        if (bus.done || bus.busy || sclk_en) seen_done++;
      end
      check("abort.quiet", 64'(seen_done), 64'd0);
    end
    rstn = 1'b1;
    tx_bytes[0] = 8'h5A;
    rx_bytes[0] = 8'h96;
    run_frame(SPECIAL_ADDR_LAST, 1, -1, -1, "after_rst");

`ifdef SPI_CTRL_RX_FIFO_EN
    // FIFO fills to depth, fifth byte overflows, sixth also dropped.
    bus.rx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tx_bytes[i] = 8'(8'hA0 + i);
      rx_bytes[i] = 8'(i + 1);
    end
    run_frame(8'h40, 6, -1, -1, "fifo");
    check("fifo.overflow", 64'(bus.rx_overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("fifo.valid", 64'(bus.rx_valid), 64'd1);
      check("fifo.data",  64'(bus.rx_data),  64'(i + 1));
      bus.rx_ready = 1'b1;
      @(negedge sclk);
      bus.rx_ready = 1'b0;
    end
    check("fifo.drained", 64'(bus.rx_valid), 64'd0);
    bus.rx_ready = 1'b1;
    run_frame(8'h41, 0, -1, -1, "fifo_clr");
    check("fifo.ovf_clear", 64'(bus.rx_overflow), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
